// File: rtl/counter_sweep_ctrl.sv
// Sequences an external up/down counter through repeated 0 -> limit -> 0 sweeps,
// with a per-leg watchdog, abort, and busy/done/error/pass progress reporting.
module counter_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PASS_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  input  logic              abort,
  input  logic              flag_max,
  input  logic              flag_min,
  output logic              load_en,
  output logic              count_inc,
  output logic              count_dec,
  output logic [WIDTH-1:0]  count_to,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [PASS_W-1:0] pass_cnt
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, FINISH, ERR} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  count_to_reg, count_to_next;
  logic [PASS_W-1:0] passes_reg, passes_next;
  logic [PASS_W-1:0] pass_cnt_reg, pass_cnt_next;
  logic              error_reg, error_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              wd_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_to_reg <= '0;
      passes_reg   <= '0;
      pass_cnt_reg <= '0;
      error_reg    <= 1'b0;
      wd_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      count_to_reg <= count_to_next;
      passes_reg   <= passes_next;
      pass_cnt_reg <= pass_cnt_next;
      error_reg    <= error_next;
      wd_reg       <= wd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_to_next = count_to_reg;
    passes_next   = passes_reg;
    pass_cnt_next = pass_cnt_reg;
    error_next    = error_reg;
    load_en       = 1'b0;
    count_inc     = 1'b0;
    count_dec     = 1'b0;
    done          = 1'b0;
    wd_expired    = (wd_reg == WD_LAST);

    case (state_reg)
      IDLE: begin
        if (start) begin
          count_to_next = limit;
          passes_next   = passes;
          pass_cnt_next = '0;
          error_next    = 1'b0;
          state_next    = (passes != '0) ? LOAD : FINISH;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = UP;
      end
      UP: begin
        count_inc = ~flag_max;
        // The exit flag wins over the watchdog when both land in the same cycle.
        if (flag_max) begin
          state_next = DOWN;
        end else if (wd_expired) begin
          state_next = ERR;
          error_next = 1'b1;
        end
      end
      DOWN: begin
        count_dec = ~flag_min;
        if (flag_min) begin
          pass_cnt_next = pass_cnt_reg + 1'b1;
          state_next    = (pass_cnt_next == passes_reg) ? FINISH : UP;
        end else if (wd_expired) begin
          state_next = ERR;
          error_next = 1'b1;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort overrides every other transition and freezes progress/error.
    if (abort && (state_reg != IDLE)) begin
      state_next    = IDLE;
      pass_cnt_next = pass_cnt_reg;
      error_next    = error_reg;
      count_inc     = 1'b0;
      count_dec     = 1'b0;
    end
  end

  always_comb begin
    wd_next = '0;
    if ((state_next == state_reg) && ((state_reg == UP) || (state_reg == DOWN))) begin
      wd_next = wd_reg + 1'b1;
    end
  end

  assign count_to = count_to_reg;
  assign pass_cnt = pass_cnt_reg;
  assign error    = error_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a behavioural up/down counter;
// each scenario task checks a per-cycle trace against hand-derived timing.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] limit;
  logic [3:0] passes;
  logic       abort;
  logic       flag_max;
  logic       flag_min;
  logic       load_en;
  logic       count_inc;
  logic       count_dec;
  logic [3:0] count_to;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] pass_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural counter attached to the controller
  logic [3:0] m_cnt;
  logic [3:0] m_to;
  logic       tie_max;

  logic       tr_load [0:31];
  logic       tr_inc  [0:31];
  logic       tr_dec  [0:31];
  logic       tr_done [0:31];
  logic       tr_busy [0:31];
  logic       tr_err  [0:31];
  logic [3:0] tr_pc   [0:31];
  logic [3:0] tr_cto  [0:31];
  int         n_inc;
  int         n_dec;
  int         n_load;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.WIDTH(4), .PASS_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .limit(limit), .passes(passes),
    .abort(abort), .flag_max(flag_max), .flag_min(flag_min),
    .load_en(load_en), .count_inc(count_inc), .count_dec(count_dec),
    .count_to(count_to), .busy(busy), .done(done), .error(error), .pass_cnt(pass_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      m_cnt <= '0;
      m_to  <= '0;
    end else if (load_en) begin
      m_cnt <= '0;
      m_to  <= count_to;
    end else if (count_inc) begin
      m_cnt <= m_cnt + 4'd1;
    end else if (count_dec) begin
      m_cnt <= m_cnt - 4'd1;
    end
  end

  assign flag_max = tie_max ? 1'b0 : (m_cnt == m_to);
  assign flag_min = (m_cnt == 4'd0);

  // Cycle 0 is the start cycle; limit/passes are scrambled afterwards to show they are ignored.
  task automatic run_seq(input logic [3:0] lim, input logic [3:0] pas, input int ncyc,
                         input int abort_at, input int restart_at);
    n_inc = 0; n_dec = 0; n_load = 0;
    for (int c = 0; c < ncyc; c++) begin
      start  = (c == 0) || (c == restart_at);
      limit  = (c == 0) ? lim : 4'hF;
      passes = (c == 0) ? pas : 4'hF;
      abort  = (c == abort_at);
      @(negedge clk);
      tr_load[c] = load_en;  tr_inc[c]  = count_inc; tr_dec[c] = count_dec;
      tr_done[c] = done;     tr_busy[c] = busy;      tr_err[c] = error;
      tr_pc[c]   = pass_cnt; tr_cto[c]  = count_to;
      n_inc  += int'(count_inc);
      n_dec  += int'(count_dec);
      n_load += int'(load_en);
      @(posedge clk); #1;
    end
    start = 0; abort = 0; limit = 0; passes = 0;
    $display("run limit=%0d passes=%0d cycles=%0d load=%0d inc=%0d dec=%0d final_pass_cnt=%0d",
             lim, pas, ncyc, n_load, n_inc, n_dec, tr_pc[ncyc-1]);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({busy, load_en, count_inc, count_dec, done, error} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=000000", {busy, load_en, count_inc, count_dec, done, error});
    end
    total++;
    if ({count_to, pass_cnt} !== 8'h00) begin
      bad++; $display("FAIL reset_regs got=%h exp=00", {count_to, pass_cnt});
    end
    @(posedge clk); #1;
    start = 1; limit = 4'd3; passes = 4'd1;
    @(posedge clk); #1;
    start = 0; limit = 0; passes = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if ({count_inc, count_to} !== {1'b1, 4'd3}) begin
      bad++; $display("FAIL reset_pre_inc_cto got=%h exp=13", {count_inc, count_to});
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    total++;
    if ({busy, load_en, count_inc, count_dec, done, error} !== 6'b0) begin
      bad++; $display("FAIL reset_mid_outputs got=%b exp=000000", {busy, load_en, count_inc, count_dec, done, error});
    end
    total++;
    if ({count_to, pass_cnt} !== 8'h00) begin
      bad++; $display("FAIL reset_mid_regs got=%h exp=00", {count_to, pass_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_pass;
    run_seq(4'd3, 4'd1, 12, -1, -1);
    for (int c = 0; c < 12; c++) begin
      total++;
      if ({tr_load[c], tr_inc[c], tr_dec[c], tr_done[c], tr_busy[c]} !==
          {c == 1, (c >= 2) && (c <= 4), (c >= 6) && (c <= 8), c == 10, (c >= 1) && (c <= 10)}) begin
        bad++;
        $display("FAIL single_trace c=%0d got=%b exp=%b", c,
                 {tr_load[c], tr_inc[c], tr_dec[c], tr_done[c], tr_busy[c]},
                 {c == 1, (c >= 2) && (c <= 4), (c >= 6) && (c <= 8), c == 10, (c >= 1) && (c <= 10)});
      end
    end
    total++;
    if (tr_pc[11] !== 4'd1) begin
      bad++; $display("FAIL single_pass_cnt got=%0d exp=1", tr_pc[11]);
    end
    total++;
    if (tr_cto[11] !== 4'd3) begin
      bad++; $display("FAIL single_count_to got=%0d exp=3", tr_cto[11]);
    end
  endtask

  task automatic test_multi_pass;
    run_seq(4'd2, 4'd3, 22, -1, -1);
    total++;
    if ({n_inc, n_dec} !== {32'd6, 32'd6}) begin
      bad++; $display("FAIL multi_pulses got inc=%0d dec=%0d exp inc=6 dec=6", n_inc, n_dec);
    end
    total++;
    if ({tr_pc[7], tr_pc[8], tr_pc[13], tr_pc[14], tr_pc[19], tr_pc[20]} !== 24'h011223) begin
      bad++; $display("FAIL multi_pass_steps got=%h exp=011223",
                      {tr_pc[7], tr_pc[8], tr_pc[13], tr_pc[14], tr_pc[19], tr_pc[20]});
    end
    for (int c = 0; c < 22; c++) begin
      total++;
      if (tr_done[c] !== (c == 20)) begin
        bad++; $display("FAIL multi_done c=%0d got=%b exp=%b", c, tr_done[c], c == 20);
      end
    end
    total++;
    if (m_cnt !== 4'd0) begin
      bad++; $display("FAIL multi_counter_end got=%0d exp=0", m_cnt);
    end
  endtask

  task automatic test_zero_cases;
    run_seq(4'd5, 4'd0, 3, -1, -1);
    total++;
    if ({tr_done[0], tr_done[1], tr_done[2], tr_busy[1]} !== 4'b0101) begin
      bad++; $display("FAIL zero_passes_done got=%b exp=0101", {tr_done[0], tr_done[1], tr_done[2], tr_busy[1]});
    end
    total++;
    if (n_load + n_inc + n_dec !== 0) begin
      bad++; $display("FAIL zero_passes_pulses got=%0d exp=0", n_load + n_inc + n_dec);
    end
    run_seq(4'd0, 4'd2, 8, -1, -1);
    for (int c = 0; c < 8; c++) begin
      total++;
      if (tr_done[c] !== (c == 6)) begin
        bad++; $display("FAIL zero_limit_done c=%0d got=%b exp=%b", c, tr_done[c], c == 6);
      end
    end
    total++;
    if ({n_inc, n_dec, 28'd0, tr_pc[7]} !== {32'd0, 32'd0, 32'd2}) begin
      bad++; $display("FAIL zero_limit_pulses got inc=%0d dec=%0d pc=%0d exp 0 0 2", n_inc, n_dec, tr_pc[7]);
    end
  endtask

  task automatic test_timeout;
    tie_max = 1'b1;
    run_seq(4'd5, 4'd1, 13, -1, -1);
    tie_max = 1'b0;
    for (int c = 0; c < 13; c++) begin
      total++;
      if ({tr_inc[c], tr_err[c], tr_busy[c], tr_done[c]} !==
          {(c >= 2) && (c <= 9), c >= 10, (c >= 1) && (c <= 10), 1'b0}) begin
        bad++;
        $display("FAIL timeout_trace c=%0d got=%b exp=%b", c, {tr_inc[c], tr_err[c], tr_busy[c], tr_done[c]},
                 {(c >= 2) && (c <= 9), c >= 10, (c >= 1) && (c <= 10), 1'b0});
      end
    end
  endtask

  task automatic test_abort;
    run_seq(4'd3, 4'd2, 10, 7, 3);
    total++;
    if ({tr_err[0], tr_err[1]} !== 2'b10) begin
      bad++; $display("FAIL abort_error_clear got=%b exp=10", {tr_err[0], tr_err[1]});
    end
    total++;
    if ({tr_dec[6], tr_dec[7], tr_busy[7], tr_busy[8]} !== 4'b1010) begin
      bad++; $display("FAIL abort_dec_busy got=%b exp=1010", {tr_dec[6], tr_dec[7], tr_busy[7], tr_busy[8]});
    end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (tr_done[c] !== 1'b0) begin
        bad++; $display("FAIL abort_no_done c=%0d got=%b exp=0", c, tr_done[c]);
      end
    end
    total++;
    if ({tr_pc[9], tr_cto[9]} !== 8'h03) begin
      bad++; $display("FAIL abort_pc_cto got=%h exp=03", {tr_pc[9], tr_cto[9]});
    end
  endtask

  task automatic test_back_to_back;
    run_seq(4'd1, 4'd1, 8, -1, -1);
    for (int c = 0; c < 8; c++) begin
      total++;
      if (tr_done[c] !== (c == 6)) begin
        bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, tr_done[c], c == 6);
      end
    end
    total++;
    if ({tr_pc[7], tr_cto[7], tr_err[7]} !== 9'b0001_0001_0) begin
      bad++; $display("FAIL b2b_final got pc=%0d cto=%0d err=%b exp 1 1 0", tr_pc[7], tr_cto[7], tr_err[7]);
    end
  endtask

  initial begin
    reset = 1; start = 0; limit = 0; passes = 0; abort = 0; tie_max = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset;
    test_single_pass;
    test_multi_pass;
    test_zero_cases;
    test_timeout;
    test_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the team's up/down counter (load_en / count_inc / count_dec / count_to / flag_max / flag_min interface). On a start command it loads the counter, then sweeps it 0 -> limit -> 0 for a programmed number of passes. It watches the counter flags to turn around, guards each sweep leg with a watchdog, and reports busy, done, error and pass progress to the host logic.

Parameters:
WIDTH, 4, counter width; width of limit and count_to
PASS_W, 4, width of passes and pass_cnt
TIMEOUT, 64, maximum cycles allowed in one sweep leg (UP or DOWN) before error; must be >= 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  start request; sampled in IDLE only
limit  input  WIDTH  sweep top value; captured on accepted start
passes  input  PASS_W  number of up+down passes; captured on accepted start
abort  input  1  cancel the running sequence
flag_max  input  1  from counter: count == count_to
flag_min  input  1  from counter: count == 0
load_en  output  1  to counter: clear count to 0 and latch count_to
count_inc  output  1  to counter: increment this cycle
count_dec  output  1  to counter: decrement this cycle
count_to  output  WIDTH  registered copy of captured limit
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on normal completion
error  output  1  sticky watchdog error
pass_cnt  output  PASS_W  completed passes in current sequence

Behaviour:
- Reset (sync, high): state=IDLE, count_to=0, pass_cnt=0, error=0, watchdog=0. All outputs 0.
- States: IDLE, LOAD, UP, DOWN, FINISH, ERR.
- IDLE: start=1 captures limit->count_to and passes->passes_reg, clears pass_cnt and error. If passes!=0, go to LOAD, else go to FINISH.
- LOAD: load_en=1 for exactly this cycle, then go to UP.
- UP: count_inc = ~flag_max & ~abort (Mealy). If flag_max=1, go to DOWN.
- DOWN: count_dec = ~flag_min & ~abort (Mealy). If flag_min=1, pass_cnt++. If the new pass_cnt == passes_reg, go to FINISH, else go to UP.
- FINISH: done=1 for this cycle only, then go to IDLE.
- ERR: error set on entry; one cycle, then go to IDLE. error stays high until the next accepted start or reset.
- Watchdog: cleared on each entry to UP/DOWN and increments each cycle in that state. If the state has lasted TIMEOUT cycles without its exit flag, go to ERR next. The exit flag takes priority over timeout in the same cycle.
- abort=1 in any non-IDLE state: go to IDLE next cycle. No done pulse, error unchanged, pass_cnt holds, inc/dec suppressed that cycle. abort has priority over all other transitions.
- start while busy is ignored; limit and passes changes while busy are ignored.
- load_en, count_inc and count_dec are mutually exclusive, and all are 0 in IDLE, FINISH and ERR.
- limit=0: flag_max and flag_min are both already true. Each leg lasts 1 cycle with no inc/dec pulses, so each pass takes 2 cycles.
- Timing, start sampled at cycle 0 with limit=L, passes=P (counter reacts on the next edge, flags combinational from count):
  - LOAD at cycle 1.
  - Each pass is L+1 UP cycles followed by L+1 DOWN cycles.
  - done is high in cycle 2+P*(2L+2).
  - Pass k completes at the end of cycle 1+k*(2L+2).
- pass_cnt wraps naturally at 2^PASS_W. This is unreachable because pass_cnt <= passes_reg.

Test Plan:
- Reset mid-sweep (assert reset in UP at cycle 4) -> next cycle state IDLE, all outputs 0, count_to=0, pass_cnt=0.
- limit=3, passes=1, start at cycle 0 -> load_en in cycle 1; count_inc in cycles 2-4; count_dec in cycles 6-8; done in cycle 10; pass_cnt=1; busy high for cycles 1-10.
- limit=2, passes=3 -> 6 inc and 6 dec pulses; pass_cnt steps 1,2,3 at ends of cycles 7,13,19; done in cycle 20; counter model ends at 0.
- passes=0 -> FINISH in cycle 1 with done=1; no load/inc/dec pulses. limit=0, passes=2 -> done in cycle 6, zero inc/dec pulses.
- TIMEOUT=8, flag_max tied 0, limit=5 -> count_inc high in cycles 2-9; ERR in cycle 10 with error=1 from cycle 10; IDLE in cycle 11; error stays 1 until next start.
- abort in DOWN at cycle 7 (limit=3, passes=2) -> count_dec=0 in cycle 7; IDLE in cycle 8; no done pulse; pass_cnt=0. A start pulse during busy has no effect.
